// File: rtl/core_dmem_target.sv
// Data-bus responder for the core's load/store port: latches one request, waits
// WAIT_STATES cycles, then commits it to a byte-enabled SRAM and pulses data_ready.
//
// Handshake: data_start is a one-cycle request strobe. It is accepted in IDLE
// or RESP and ignored in WAIT (protocol_err becomes sticky). data_ready is a
// one-cycle response strobe. data_data_rd and data_fault are valid only while
// data_ready is high; data_data_rd keeps its last value at all other times.
module core_dmem_target #(
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [29:0] BASE        = 30'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_start,
    input  logic        data_write,
    input  logic [29:0] data_addr,
    input  logic [31:0] data_data_wr,
    input  logic [3:0]  data_data_be,
    output logic        data_ready,
    output logic [31:0] data_data_rd,
    output logic        data_fault,
    output logic        protocol_err,
    output logic [1:0]  dbg_state
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam int unsigned CNT_W = $clog2(WAIT_STATES + 2);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hold_write_q, hold_write_d;
    logic [29:0]       hold_addr_q, hold_addr_d;
    logic [31:0]       hold_wdata_q, hold_wdata_d;
    logic [3:0]        hold_be_q, hold_be_d;
    logic              data_ready_q, data_ready_d;
    logic              data_fault_q, data_fault_d;
    logic              protocol_err_q, protocol_err_d;
    logic [31:0]       data_data_rd_q, data_data_rd_d;

    logic [31:0]       mem [DEPTH];

    logic              do_access;
    logic              use_inputs;
    logic              acc_write;
    logic [29:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_be;
    logic [29:0]       acc_index;
    logic              acc_in_range;
    logic [ADDR_BITS-1:0] acc_row;
    logic [31:0]       rd_word;
    logic              mem_we;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hold_write_d   = hold_write_q;
        hold_addr_d    = hold_addr_q;
        hold_wdata_d   = hold_wdata_q;
        hold_be_d      = hold_be_q;
        protocol_err_d = protocol_err_q;
        do_access      = 1'b0;
        use_inputs     = 1'b0;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (data_start) begin
                    hold_write_d = data_write;
                    hold_addr_d  = data_addr;
                    hold_wdata_d = data_data_wr;
                    hold_be_d    = data_data_be;
                    cnt_d        = CNT_LOAD;
                    // With no wait states the access commits on the accepting
                    // edge, so it must use the request straight off the bus.
                    if (WAIT_STATES == 0) begin
                        do_access  = 1'b1;
                        use_inputs = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (data_start) begin
                    protocol_err_d = 1'b1;
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    do_access = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        acc_write = use_inputs ? data_write   : hold_write_q;
        acc_addr  = use_inputs ? data_addr    : hold_addr_q;
        acc_wdata = use_inputs ? data_data_wr : hold_wdata_q;
        acc_be    = use_inputs ? data_data_be : hold_be_q;
    end

    // Modulo-2^30 subtraction: addresses below BASE wrap high and fall out of range.
    always_comb begin
        acc_index    = acc_addr - BASE;
        acc_in_range = ((acc_index >> ADDR_BITS) == 30'd0);
        acc_row      = acc_index[ADDR_BITS-1:0];
        rd_word      = mem[acc_row];

        data_ready_d   = do_access;
        data_fault_d   = do_access && !acc_in_range;
        data_data_rd_d = data_data_rd_q;
        if (do_access && !acc_write) begin
            data_data_rd_d = acc_in_range ? rd_word : 32'h0;
        end
        mem_we = do_access && acc_write && acc_in_range && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            hold_write_q   <= 1'b0;
            hold_addr_q    <= '0;
            hold_wdata_q   <= '0;
            hold_be_q      <= '0;
            data_ready_q   <= 1'b0;
            data_fault_q   <= 1'b0;
            protocol_err_q <= 1'b0;
            data_data_rd_q <= 32'h0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            hold_write_q   <= hold_write_d;
            hold_addr_q    <= hold_addr_d;
            hold_wdata_q   <= hold_wdata_d;
            hold_be_q      <= hold_be_d;
            data_ready_q   <= data_ready_d;
            data_fault_q   <= data_fault_d;
            protocol_err_q <= protocol_err_d;
            data_data_rd_q <= data_data_rd_d;
        end
    end

    // Array contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_row][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign data_ready   = data_ready_q;
    assign data_fault   = data_fault_q;
    assign protocol_err = protocol_err_q;
    assign data_data_rd = data_data_rd_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_core_dmem_target.sv
// Bench for core_dmem_target: three instances (2, 0 and 1 wait states) share one
// stimulus stream and are each compared cycle by cycle against a request/response model.
module tb_core_dmem_target;

    localparam int          NDUT  = 3;
    localparam int          ABITS = 6;
    localparam logic [29:0] BASE  = 30'h20;

    int ws_tab [NDUT] = '{2, 0, 1};

    logic        clk;
    logic        rst;
    logic        start;
    logic        wr;
    logic [29:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [NDUT-1:0] rdy;
    logic [NDUT-1:0] flt;
    logic [NDUT-1:0] perr;
    logic [31:0] rd  [NDUT];
    logic [1:0]  dbg [NDUT];

    core_dmem_target #(.ADDR_BITS(ABITS), .WAIT_STATES(2), .BASE(BASE)) u_w2 (
        .clk(clk), .rst(rst), .data_start(start), .data_write(wr), .data_addr(addr),
        .data_data_wr(wd), .data_data_be(be), .data_ready(rdy[0]), .data_data_rd(rd[0]),
        .data_fault(flt[0]), .protocol_err(perr[0]), .dbg_state(dbg[0]));

    core_dmem_target #(.ADDR_BITS(ABITS), .WAIT_STATES(0), .BASE(BASE)) u_w0 (
        .clk(clk), .rst(rst), .data_start(start), .data_write(wr), .data_addr(addr),
        .data_data_wr(wd), .data_data_be(be), .data_ready(rdy[1]), .data_data_rd(rd[1]),
        .data_fault(flt[1]), .protocol_err(perr[1]), .dbg_state(dbg[1]));

    core_dmem_target #(.ADDR_BITS(ABITS), .WAIT_STATES(1), .BASE(BASE)) u_w1 (
        .clk(clk), .rst(rst), .data_start(start), .data_write(wr), .data_addr(addr),
        .data_data_wr(wd), .data_data_be(be), .data_ready(rdy[2]), .data_data_rd(rd[2]),
        .data_fault(flt[2]), .protocol_err(perr[2]), .dbg_state(dbg[2]));

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: memory image, one pending request, expected next outputs
    logic [31:0] mmem   [NDUT][64];
    logic        pend   [NDUT];
    int          left   [NDUT];
    logic        p_wr   [NDUT];
    logic [29:0] p_addr [NDUT];
    logic [31:0] p_wd   [NDUT];
    logic [3:0]  p_be   [NDUT];
    logic        exp_rdy  [NDUT];
    logic        exp_flt  [NDUT];
    logic        exp_perr [NDUT];
    logic [31:0] exp_rd   [NDUT];

    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic commit(input int m, input logic w, input logic [29:0] a,
                          input logic [31:0] d, input logic [3:0] b);
        logic [29:0] idx;
        idx = a - BASE;
        exp_rdy[m] = 1'b1;
        if (idx < 30'd64) begin
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) mmem[m][idx[5:0]][8*i +: 8] = d[8*i +: 8];
            end else begin
                exp_rd[m] = mmem[m][idx[5:0]];
            end
        end else begin
            exp_flt[m] = 1'b1;
            if (!w) exp_rd[m] = 32'h0;
        end
    endtask

    task automatic model_step(input int m);
        logic busy;
        if (rst) begin
            pend[m] = 1'b0; exp_rdy[m] = 1'b0; exp_flt[m] = 1'b0;
            exp_perr[m] = 1'b0; exp_rd[m] = 32'h0;
            return;
        end
        busy = pend[m];
        exp_rdy[m] = 1'b0;
        exp_flt[m] = 1'b0;
        if (busy && start) exp_perr[m] = 1'b1;
        if (busy) begin
            left[m]--;
            if (left[m] == 0) begin
                pend[m] = 1'b0;
                commit(m, p_wr[m], p_addr[m], p_wd[m], p_be[m]);
            end
        end
        if (start && !busy) begin
            if (ws_tab[m] == 0) begin
                commit(m, wr, addr, wd, be);
            end else begin
                pend[m] = 1'b1; left[m] = ws_tab[m];
                p_wr[m] = wr; p_addr[m] = addr; p_wd[m] = wd; p_be[m] = be;
            end
        end
    endtask

    // Driver: check the current cycle's outputs, apply this cycle's inputs, advance model
    task automatic cycle(input logic s, input logic w, input logic [29:0] a,
                         input logic [31:0] d, input logic [3:0] b, input logic r);
        @(negedge clk);
        for (int m = 0; m < NDUT; m++) begin
            check($sformatf("u%0d.ready", m), 32'(rdy[m]),  32'(exp_rdy[m]));
            check($sformatf("u%0d.fault", m), 32'(flt[m]),  32'(exp_flt[m]));
            check($sformatf("u%0d.perr",  m), 32'(perr[m]), 32'(exp_perr[m]));
            check($sformatf("u%0d.rdata", m), rd[m], exp_rd[m]);
        end
        start = s; wr = w; addr = a; wd = d; be = b; rst = r;
        for (int m = 0; m < NDUT; m++) model_step(m);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic req(input logic w, input logic [29:0] a, input logic [31:0] d, input logic [3:0] b);
        cycle(1'b1, w, a, d, b, 1'b0);
        idle(2);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b1);
        idle(1);
    endtask

    initial begin
        logic        s, w, r;
        logic [29:0] a;
        int          sel;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; start = 1'b0; wr = 1'b0; addr = '0; wd = '0; be = '0;
        for (int m = 0; m < NDUT; m++) begin
            pend[m] = 1'b0; left[m] = 0; exp_rdy[m] = 1'b0; exp_flt[m] = 1'b0;
            exp_perr[m] = 1'b0; exp_rd[m] = 32'h0;
            p_wr[m] = 1'b0; p_addr[m] = '0; p_wd[m] = '0; p_be[m] = '0;
        end
        cycle(1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b1);
        idle(1);

        // Give every in-range word a known value
        for (int i = 0; i < 64; i++) req(1'b1, BASE + 30'(i), $urandom, 4'hF);

        // Full-word store then load
        req(1'b1, BASE + 30'd5, 32'hDEADBEEF, 4'hF);
        req(1'b0, BASE + 30'd5, 32'h0, 4'h0);

        // Partial stores, including an all-lanes-off store
        req(1'b1, BASE + 30'd7, 32'h11223344, 4'hF);
        req(1'b1, BASE + 30'd7, 32'hAABBCCDD, 4'b0101);
        req(1'b0, BASE + 30'd7, 32'h0, 4'h0);
        req(1'b1, BASE + 30'd7, 32'h55555555, 4'b0000);
        req(1'b0, BASE + 30'd7, 32'h0, 4'h0);

        // Back-to-back starts (protocol error for the wait-state instances)
        cycle(1'b1, 1'b1, BASE + 30'd3, 32'h1, 4'hF, 1'b0);
        cycle(1'b1, 1'b0, BASE + 30'd3, 32'h0, 4'hF, 1'b0);
        cycle(1'b1, 1'b0, BASE + 30'd3, 32'h0, 4'hF, 1'b0);
        idle(3);
        do_reset();

        // Out-of-range load, and a store below BASE that wraps
        req(1'b0, 30'h500, 32'h0, 4'hF);
        req(1'b1, BASE - 30'd1, 32'hFFFFFFFF, 4'hF);
        req(1'b0, BASE, 32'h0, 4'h0);
        req(1'b0, BASE + 30'd63, 32'h0, 4'h0);
        req(1'b0, BASE + 30'd64, 32'h0, 4'h0);

        // Second start two cycles after the first
        cycle(1'b1, 1'b0, BASE + 30'd2, 32'h0, 4'h0, 1'b0);
        idle(1);
        cycle(1'b1, 1'b1, BASE + 30'd2, 32'h0BADF00D, 4'hF, 1'b0);
        idle(4);
        req(1'b0, BASE + 30'd2, 32'h0, 4'h0);
        do_reset();

        // Reset while a store is pending
        req(1'b1, BASE + 30'd9, 32'h12345678, 4'hF);
        cycle(1'b1, 1'b1, BASE + 30'd9, 32'hCAFE0000, 4'hF, 1'b0);
        cycle(1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b1);
        idle(3);
        req(1'b0, BASE + 30'd9, 32'h0, 4'h0);

        // Randomized traffic
        repeat (4000) begin
            r = ($urandom_range(0, 99) == 0);
            s = pend[0] ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 1) == 1);
            w = ($urandom_range(0, 1) == 1);
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = BASE + 30'($urandom_range(0, 63));
            else if (sel == 7) a = 30'($urandom_range(0, 31));
            else if (sel == 8) a = BASE + 30'($urandom_range(64, 95));
            else               a = 30'($urandom);
            cycle(s, w, a, $urandom, 4'($urandom_range(0, 15)), r);
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/core_dmem_target.md
# core_dmem_target

Data-bus responder for the core's load/store port. It accepts one word-addressed request per `data_start` pulse and holds the request internally. It serves the request from an internal byte-enabled SRAM after a configurable number of wait states, then answers with a one-cycle `data_ready` pulse carrying read data. It sits on the memory side of the core's data port and is the counterpart of the load/store unit's request logic.

## Interface
Parameters:
- `ADDR_BITS`, default 10: log2 of array depth in 32-bit words. The default gives 1024 words (4 KiB).
- `WAIT_STATES`, default 1: extra cycles between request acceptance and response. Must be ≥ 0.
- `BASE`, default 30'h0: word address (ptr) of array entry 0.

Ports:
- `clk`  in  1: clock. Single clock domain; all logic on the rising edge.
- `rst`  in  1: reset. Synchronous, active-high.
- `data_start`  in  1: request strobe. One cycle wide.
- `data_write`  in  1: 1 = store, 0 = load. Sampled with `data_start`.
- `data_addr`  in  30: word address (byte address [31:2]). Sampled with `data_start`.
- `data_data_wr`  in  32: store data. Sampled with `data_start`.
- `data_data_be`  in  4: byte lane enables. Bit i enables bits [8i+7:8i]. Sampled with `data_start`.
- `data_ready`  out  1: response strobe. One cycle wide.
- `data_data_rd`  out  32: load data. Valid while `data_ready`=1.
- `data_fault`  out  1: out-of-range access. Pulses together with `data_ready`.
- `protocol_err`  out  1: sticky flag. Set when `data_start` arrives while busy.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE, `data_start`=1: latch write, addr, wdata and be into holding registers. Load the wait counter with WAIT_STATES.
  - If WAIT_STATES > 0, go to WAIT.
  - Otherwise perform the access and go to RESP.
- WAIT: decrement the counter each cycle. On the cycle the counter reads 1, perform the access and go to RESP.
- Access, committed on the edge that enters RESP. Index = held addr − BASE; in range iff index < 2^ADDR_BITS.
  - In-range store: write only the enabled lanes; other lanes keep old contents. be=4'b0000 writes nothing but is still acknowledged.
  - In-range load: `data_data_rd` ← full word at index. be is ignored on loads.
  - Out-of-range store: dropped, array unchanged. `data_fault`=1 in RESP.
  - Out-of-range load: `data_data_rd` ← 32'h0. `data_fault`=1 in RESP.
- RESP: `data_ready`=1 for exactly this cycle.
  - `data_start`=1 in RESP is a legal back-to-back request. It is accepted exactly as from IDLE, and the next state is WAIT or RESP.
  - Otherwise go to IDLE.
- `data_start`=1 in WAIT is ignored: no latch, no effect on the pending access. `protocol_err` sets and stays 1 until `rst`.
- `data_data_rd` holds its last value outside RESP. Stores do not modify it.
- Accesses are strictly in order, so a load following a store to the same word returns the stored data.
- Index subtraction is 30-bit modulo. An address below BASE wraps to a large index and is therefore out of range.

## Timing
- Request in cycle 0 (`data_start` high). WAIT occupies cycles 1..WAIT_STATES. `data_ready` is high in cycle WAIT_STATES+1. Latency = WAIT_STATES+1 cycles.
- Throughput: one request per WAIT_STATES+1 cycles with back-to-back starts issued in RESP.
- All outputs are registered; none depends combinationally on inputs.
- Reset values: state IDLE; `data_ready`=0, `data_fault`=0, `protocol_err`=0, `data_data_rd`=32'h0, counter=0.
- Array contents are not reset.
- `rst` high in any state:
  - Next state is IDLE.
  - A pending access that has not yet committed is discarded; in particular, a store in WAIT never reaches the array.
  - `rst` takes priority over a simultaneous `data_start`.
- `data_ready` and `data_fault` are never high outside RESP.

## Test plan
- WAIT_STATES=1, BASE=0. Store addr 5, wdata 32'hDEADBEEF, be 4'hF in cycle 0 → `data_ready` in cycle 2 only, `data_fault`=0. Then load addr 5 → `data_data_rd`=32'hDEADBEEF with `data_ready` 2 cycles after its start.
- Partial store. Word 7 = 32'h11223344, then store 32'hAABBCCDD with be 4'b0101, then load 7 → 32'h11BB33DD. A be=4'b0000 store leaves 32'h11BB33DD and still pulses `data_ready`.
- Back-to-back, WAIT_STATES=0. `data_start` high in cycles 0, 1 and 2 (store 3=32'h1, load 3, load 3) → `data_ready` high in cycles 1, 2 and 3. Both loads return 32'h1.
- Out of range, BASE=30'h100, ADDR_BITS=10. Load 30'h500 → `data_data_rd`=0 with `data_fault`=1. Store 30'h0FF (wraps) → `data_fault`=1 and no array entry changes.
- Protocol error, WAIT_STATES=3. `data_start` in cycle 0 (load 2) and again in cycle 2 → single `data_ready` in cycle 4 with the cycle-0 request's data. `protocol_err`=1 from cycle 3 until `rst`.
- Reset mid-operation, WAIT_STATES=2. Store addr 9 = 32'hCAFE0000 (prior 32'h12345678), `rst` in cycle 1 → no `data_ready` and all outputs at reset values. A following load of 9 returns 32'h12345678.
